// File: rtl/i2s_pkg.sv
// Shared types and defaults for the I2S receive path.
// Sample width default, receiver state encoding and sample type.
package i2s_pkg;

    localparam int SAMPLE_WIDTH = 24;

    typedef enum logic [1:0] {
        IDLE,
        SHIFT,
        HOLD
    } rx_state_t;

    typedef logic [SAMPLE_WIDTH-1:0] sample_t;

endpackage

// File: rtl/i2s_sync.sv
// Multi-flop synchroniser for asynchronous I2S pins.
// With EDGE=1 the output is a one-cycle rising-edge pulse, else the level.
module i2s_sync #(
    parameter int STAGES = 2,
    parameter int WIDTH  = 1,
    parameter bit EDGE   = 1'b0
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [WIDTH-1:0] d,
    output logic [WIDTH-1:0] q
);

    logic [WIDTH-1:0] sr [STAGES];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < STAGES; i++) sr[i] <= '0;
        end else begin
            sr[0] <= d;
            for (int i = 1; i < STAGES; i++) sr[i] <= sr[i-1];
        end
    end

    generate
        if (EDGE) begin : g_edge
            logic [WIDTH-1:0] hist;
            always_ff @(posedge clk or negedge rst_n) begin
                if (!rst_n) hist <= '0;
                else        hist <= sr[STAGES-1];
            end
            assign q = sr[STAGES-1] & ~hist;
        end else begin : g_level
            assign q = sr[STAGES-1];
        end
    endgenerate

endmodule

// File: rtl/i2s_rx.sv
// I2S receiver: oversamples SCLK/LRCLK/Din on CLK and emits
// left/right sample pairs on a valid/ready stream.
module i2s_rx
    import i2s_pkg::*;
#(
    parameter int SAMPLE_WIDTH = i2s_pkg::SAMPLE_WIDTH,
    parameter int SYNC_STAGES  = 2
) (
    input  logic                    CLK,
    input  logic                    RESET,
    input  logic                    SCLK,
    input  logic                    LRCLK,
    input  logic                    Din,
    input  logic                    enable,
    output logic [SAMPLE_WIDTH-1:0] out_left,
    output logic [SAMPLE_WIDTH-1:0] out_right,
    output logic                    out_valid,
    input  logic                    out_ready,
    output logic                    locked,
    output logic                    overrun,
    input  logic                    overrun_clr
);

    localparam int W  = SAMPLE_WIDTH;
    localparam int CW = $clog2(W + 1);
    localparam logic [CW-1:0] W_C = CW'(W);

    logic sclk_rise;
    logic lr_now;
    logic din;

    i2s_sync #(.STAGES(SYNC_STAGES), .WIDTH(1), .EDGE(1'b1)) u_sclk (
        .clk   (CLK),
        .rst_n (RESET),
        .d     (SCLK),
        .q     (sclk_rise)
    );

    i2s_sync #(.STAGES(SYNC_STAGES), .WIDTH(2), .EDGE(1'b0)) u_lvl (
        .clk   (CLK),
        .rst_n (RESET),
        .d     ({LRCLK, Din}),
        .q     ({lr_now, din})
    );

    rx_state_t     state, state_d;
    logic          lr_prev;
    logic [W-1:0]  shreg, shreg_d;
    logic [CW-1:0] bitcnt, bitcnt_d;
    logic [CW-1:0] bitcnt_inc;
    logic [CW-1:0] pad_sh;
    logic [W-1:0]  shifted;
    logic          lr_edge;
    logic          commit;
    logic [W-1:0]  word;

    assign lr_edge    = sclk_rise && (lr_now != lr_prev);
    assign shifted    = {shreg[W-2:0], din};
    assign bitcnt_inc = bitcnt + 1'b1;
    assign pad_sh     = W_C - bitcnt_inc;
    assign locked     = (state != IDLE);

    always_comb begin
        state_d  = state;
        bitcnt_d = bitcnt;
        shreg_d  = shreg;
        commit   = 1'b0;
        word     = '0;
        if (!enable) begin
            state_d  = IDLE;
            bitcnt_d = '0;
        end else if (sclk_rise) begin
            unique case (state)
                IDLE: begin
                    if (lr_edge) begin
                        state_d  = SHIFT;
                        bitcnt_d = '0;
                    end
                end
                SHIFT: begin
                    if (lr_edge) begin
                        // edge bit is the LSB of the word being closed
                        if (bitcnt != '0) begin
                            commit = 1'b1;
                            word   = shifted << pad_sh;
                        end
                        bitcnt_d = '0;
                    end else begin
                        shreg_d  = shifted;
                        bitcnt_d = bitcnt_inc;
                        if (bitcnt_inc == W_C) begin
                            commit  = 1'b1;
                            word    = shifted;
                            state_d = HOLD;
                        end
                    end
                end
                HOLD: begin
                    if (lr_edge) begin
                        state_d  = SHIFT;
                        bitcnt_d = '0;
                    end
                end
                default: state_d = IDLE;
            endcase
        end
    end

    logic         cm_vld;
    logic         cm_ch;
    logic [W-1:0] cm_word;

    always_ff @(posedge CLK or negedge RESET) begin
        if (!RESET) begin
            state   <= IDLE;
            bitcnt  <= '0;
            shreg   <= '0;
            lr_prev <= 1'b0;
            cm_vld  <= 1'b0;
            cm_ch   <= 1'b0;
            cm_word <= '0;
        end else begin
            state   <= state_d;
            bitcnt  <= bitcnt_d;
            shreg   <= shreg_d;
            if (sclk_rise) lr_prev <= lr_now;
            cm_vld  <= commit;
            cm_ch   <= lr_prev;
            cm_word <= word;
        end
    end

    logic         have_left;
    logic [W-1:0] left_hold;
    logic         pair;
    logic         load;

    assign pair = cm_vld && cm_ch && have_left;
    assign load = pair && (!out_valid || out_ready);

    always_ff @(posedge CLK or negedge RESET) begin
        if (!RESET) begin
            have_left <= 1'b0;
            left_hold <= '0;
            out_left  <= '0;
            out_right <= '0;
            out_valid <= 1'b0;
            overrun   <= 1'b0;
        end else begin
            if (!enable) begin
                have_left <= 1'b0;
            end else if (cm_vld) begin
                if (!cm_ch) begin
                    left_hold <= cm_word;
                    have_left <= 1'b1;
                end else begin
                    have_left <= 1'b0;
                end
            end
            if (load) begin
                out_left  <= left_hold;
                out_right <= cm_word;
                out_valid <= 1'b1;
            end else if (out_ready) begin
                out_valid <= 1'b0;
            end
            if (pair && out_valid && !out_ready) overrun <= 1'b1;
            else if (overrun_clr)                overrun <= 1'b0;
        end
    end

endmodule
